// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit FIFO slice.
package uart_pkg;

  localparam int UART_NB_DATA = 8;
  localparam int UART_DEPTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Signal bundle between the debug-side writer, the FIFO and the UART transmitter.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int NB_DATA = UART_NB_DATA,
  parameter int NB_ADDR = 4
) ();

  // i_push is a one-cycle write strobe with no back-pressure (dropped when full);
  // o_tx_start/i_tx_done are one-cycle pulses with at most one byte outstanding.
  logic [NB_DATA-1:0] i_data;
  logic               i_push;
  logic               i_tx_done;
  logic               o_full;
  logic               o_empty;
  logic [NB_ADDR:0]   o_count;
  logic               o_overflow;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_busy;
  tx_state_e          o_state;

  modport slave (
    input  i_data, i_push, i_tx_done,
    output o_full, o_empty, o_count, o_overflow, o_tx_start, o_tx_data, o_busy, o_state
  );

  modport master (
    output i_data, i_push, i_tx_done,
    input  o_full, o_empty, o_count, o_overflow, o_tx_start, o_tx_data, o_busy, o_state
  );

endinterface

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int NB_DATA = 8,
  parameter int DEPTH   = 16,
  parameter int NB_ADDR = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [NB_ADDR-1:0] waddr,
  input  logic [NB_DATA-1:0] wdata,
  input  logic [NB_ADDR-1:0] raddr,
  output logic [NB_DATA-1:0] rdata
);

  logic [NB_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter one byte at a time via start/done pulses.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int NB_DATA = UART_NB_DATA,
  parameter int DEPTH   = UART_DEPTH,
  parameter int NB_ADDR = 4
) (
  input  logic            clk,
  input  logic            i_rst,
  uart_tx_fifo_if.slave   bus
);

  localparam logic [NB_ADDR:0]   FULL_CNT = (NB_ADDR+1)'(DEPTH);
  localparam logic [NB_ADDR-1:0] PTR_ONE  = NB_ADDR'(1);

  tx_state_e          state, state_next;
  logic [NB_ADDR:0]   count, count_next;
  logic [NB_ADDR-1:0] wr_ptr, rd_ptr;
  logic [NB_DATA-1:0] head, data_q, data_next;
  logic               push_ok, pop, start_q, start_next;
  logic               full_q, empty_q, ovf_q, busy_q;

  fifo_mem #(
    .NB_DATA (NB_DATA),
    .DEPTH   (DEPTH),
    .NB_ADDR (NB_ADDR)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok && !i_rst),
    .waddr (wr_ptr),
    .wdata (bus.i_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pop decision uses the registered count, so a byte written this cycle is never popped this cycle.
  assign push_ok = bus.i_push && (count != FULL_CNT);

  always_comb begin
    state_next = state;
    start_next = 1'b0;
    data_next  = data_q;
    pop        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          start_next = 1'b1;
          data_next  = head;
          state_next = ST_SEND;
        end
      end
      ST_SEND:      state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.i_tx_done) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    count_next = count + {{NB_ADDR{1'b0}}, push_ok} - {{NB_ADDR{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      start_q <= start_next;
      data_q  <= data_next;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (bus.i_push && !push_ok) ovf_q <= 1'b1;
      full_q  <= (count_next == FULL_CNT);
      empty_q <= (count_next == '0);
      busy_q  <= (state_next != ST_IDLE) || (count_next != '0);
    end
  end

  assign bus.o_full     = full_q;
  assign bus.o_empty    = empty_q;
  assign bus.o_count    = count;
  assign bus.o_overflow = ovf_q;
  assign bus.o_tx_start = start_q;
  assign bus.o_tx_data  = data_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_state    = state;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter NB_DATA, default 8, byte width.
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, minimum 2.
REQ-003 Parameter NB_ADDR, default 4, pointer width, equal to log2(DEPTH).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all state updates on rising edge.
REQ-006 i_rst  in  1  synchronous active-high reset.
REQ-007 i_data  in  NB_DATA  byte from the debug interface.
REQ-008 i_push  in  1  write strobe; one byte per cycle high.
REQ-009 o_full  out  1  high when count equals DEPTH.
REQ-010 o_empty  out  1  high when count equals 0.
REQ-011 o_count  out  NB_ADDR+1  stored bytes, range 0..DEPTH.
REQ-012 o_overflow  out  1  sticky flag: a push was dropped.
REQ-013 i_tx_done  in  1  one-cycle done pulse from the UART transmitter.
REQ-014 o_tx_start  out  1  one-cycle start pulse to the UART transmitter.
REQ-015 o_tx_data  out  NB_DATA  byte presented to the UART transmitter.
REQ-016 o_busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-017 Pushes SHALL be accepted when o_full is 0; the write pointer and count increment on the same edge.
REQ-018 A push while o_full is 1 SHALL be dropped, with contents unchanged and o_overflow set until reset.
REQ-019 Pointers SHALL wrap modulo DEPTH; the full/empty decision uses count, not pointer equality.
REQ-020 The FSM SHALL have three states: IDLE, SEND, WAIT_DONE. All outputs are registered.
REQ-021 IDLE, non-empty: on the next edge, latch the head byte into o_tx_data, pop, set o_tx_start to 1, go to SEND.
REQ-022 SEND: on the next edge, clear o_tx_start and go to WAIT_DONE; o_tx_start is therefore high for exactly one cycle.
REQ-023 WAIT_DONE: hold o_tx_data stable; go to IDLE on the edge where i_tx_done is 1.
REQ-024 i_tx_done SHALL be ignored in IDLE and SEND.
REQ-025 Latency: a push sampled at edge k into an empty FIFO with the FSM in IDLE SHALL produce o_tx_start high in the cycle after edge k+1.
REQ-026 Back-to-back bytes: the next o_tx_start SHALL occur no earlier than the cycle after the edge following the i_tx_done edge.
REQ-027 Simultaneous push and pop with o_full 0 SHALL both take effect; count is unchanged.
REQ-028 A byte pushed in a given cycle SHALL NOT be popped in that same cycle.
REQ-029 Bytes SHALL be transmitted in push order with no loss or duplication.

Reset
REQ-030 i_rst SHALL set:
- pointers and count to 0
- o_empty to 1; o_full, o_overflow, o_tx_start, o_busy to 0
- o_tx_data to 0
- FSM to IDLE
REQ-031 Reset mid-operation SHALL discard stored bytes; a byte already handed to the transmitter is not recalled.
REQ-032 Storage array contents need no reset.

Structure
REQ-033 Shared package uart_pkg SHALL hold NB_DATA, the default DEPTH, and the FSM state encoding constants.
REQ-034 Storage SHALL be a sub-module fifo_mem: DEPTH x NB_DATA register array with one synchronous write port and one asynchronous read port. Pointer, count and FSM logic stay in uart_tx_fifo.

Verification
REQ-035 Reset, then push 0xA5 once -> o_tx_start pulse one cycle after the edge following the push, o_tx_data = 0xA5, o_count back to 0.
REQ-036 Push 0x01..0x10 (16 bytes) back-to-back with i_tx_done held low -> first byte popped, o_count reaches 15, 16 accepted, o_overflow stays 0; one more push of 0x11 is still accepted (count 16, o_full 1); a further push of 0x12 -> dropped, o_overflow 1.
REQ-037 Model i_tx_done as a pulse 10 cycles after each start; push 0x10..0x2F -> 32 bytes emitted in order, pointer wrap exercised, o_busy drops to 0 after the last done.
REQ-038 With the FIFO at count 5, push on the same cycle as a pop -> count remains 5, data order preserved.
REQ-039 Assert i_rst while in WAIT_DONE with 3 bytes queued -> next cycle: o_count 0, o_empty 1, o_tx_start 0, FSM IDLE, no further starts.
REQ-040 Pulse i_tx_done while in IDLE with the FIFO empty -> no state change, no o_tx_start.
